// File: rtl/fanout_pkg.sv
// fanout_pkg: shared defaults and mask type for the fanout fork
package fanout_pkg;
  localparam int FANOUT_NUM_OUT_DEF = 9;
  localparam int FANOUT_DATA_W_DEF  = 32;
  localparam int FANOUT_CNT_W_DEF   = 16;
  typedef logic [FANOUT_NUM_OUT_DEF-1:0] fanout_mask_t;
endpackage

// File: rtl/fanout_tok_counter.sv
// fanout_tok_counter: saturating token counter with clear priority over increment
module fanout_tok_counter
  import fanout_pkg::*;
#(
  parameter int CNT_W = FANOUT_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  // count up on inc, stick at all-ones, clear or reset wins
  always_ff @(posedge clk)
    cnt <= (reset | clr) ? '0 : (inc & ~&cnt) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/fanout_fork_eager.sv
// fanout_fork_eager: broadcast one valid/ready stream to NUM_OUT branches; FANOUT_EAGER_EN selects eager (per-branch delivery tracking) over lazy (all-at-once) fork
module fanout_fork_eager
  import fanout_pkg::*;
#(
  parameter int NUM_OUT = FANOUT_NUM_OUT_DEF,
  parameter int DATA_W  = FANOUT_DATA_W_DEF,
  parameter int CNT_W   = FANOUT_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic [NUM_OUT-1:0] en,
  input  logic [NUM_OUT-1:0] sel,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_OUT-1:0] pending,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   tok_cnt
);
  logic [NUM_OUT-1:0] active;
  logic               accept;
  assign active   = en & sel;
  assign out_data = in_data;
  assign accept   = in_valid & in_ready;
`ifdef FANOUT_EAGER_EN
  logic [NUM_OUT-1:0] done;
  // token leaves once every active branch has taken it or takes it now
  always_comb begin
    in_ready  = &(~active | done | out_ready);
    out_valid = {NUM_OUT{in_valid}} & active & ~done;
    pending   = in_valid ? (active & ~done) : '0;
  end
  // remember which branches already took the token until it is accepted
  always_ff @(posedge clk)
    done <= (reset | accept) ? '0 : done | (out_valid & out_ready);
`else
  // all active branches must be ready together, so they fire in one cycle
  always_comb begin
    in_ready  = &(~active | out_ready);
    out_valid = {NUM_OUT{in_valid & in_ready}} & active;
    pending   = in_valid ? active : '0;
  end
`endif
  fanout_tok_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (accept),
    .cnt  (tok_cnt)
  );
endmodule

// File: tb/tb_fanout_fork_eager.sv
// tb_fanout_fork_eager: randomized self-checking bench against a delivery-set reference model
module tb_fanout_fork_eager;
  localparam int N = 3, DW = 8, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FANOUT_EAGER_EN
  localparam bit EAGER = 1'b1;
`else
  localparam bit EAGER = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, cnt_clr;
  logic [DW-1:0] in_data, out_data;
  logic [N-1:0] en, sel, out_valid, out_ready, pending;
  logic [CW-1:0] tok_cnt;
  int checks = 0, errors = 0;
  bit got[N];
  int mcnt;
  logic e_ready;
  logic [N-1:0] e_ov, e_pend;

  fanout_fork_eager #(.NUM_OUT(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .en(en), .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .pending(pending), .cnt_clr(cnt_clr), .tok_cnt(tok_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic bit any_got();
    for (int i = 0; i < N; i++) if (got[i]) return 1'b1;
    return 1'b0;
  endfunction

  // expected combinational view: a branch is owed the token if it is routed and has not received it
  function automatic void eval();
    e_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bit act;
      act = en[i] && sel[i];
      if (act && !got[i] && !out_ready[i]) e_ready = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      bit act, owed;
      act  = en[i] && sel[i];
      owed = act && !got[i];
      e_ov[i]   = EAGER ? (in_valid && owed) : (in_valid && act && e_ready);
      e_pend[i] = in_valid && owed;
    end
  endfunction

  task automatic tick();
    bit acc;
    @(posedge clk);
    eval();
    assert (reset || in_valid || !any_got()) else $error("protocol: in_valid dropped mid-token");
    if (reset) begin
      for (int i = 0; i < N; i++) got[i] = 1'b0;
      mcnt = 0;
    end else begin
      acc = in_valid && e_ready;
      for (int i = 0; i < N; i++) got[i] = acc ? 1'b0 : (got[i] || (e_ov[i] && out_ready[i]));
      mcnt = cnt_clr ? 0 : acc ? ((mcnt == CMAX) ? CMAX : mcnt + 1) : mcnt;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; en = '1; sel = '1; out_ready = '0; cnt_clr = 0; in_data = '0;
    tick(); tick();
    reset = 0;
    #1; eval();
    checks++; if (tok_cnt !== '0) begin errors++; $display("FAIL reset tok_cnt got %0d exp 0", tok_cnt); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset pending got %b exp 000", pending); end
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset out_valid got %b exp 000", out_valid); end
    checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL reset in_ready got %b exp %b", in_ready, e_ready); end
    en = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready_idle got %b exp 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] toks [3];
    int dfire[N];
    toks[0] = 8'h0A; toks[1] = 8'h0B; toks[2] = 8'h0C;
    for (int i = 0; i < N; i++) dfire[i] = 0;
    en = '1; sel = '1; out_ready = '1; in_valid = 1;
    for (int t = 0; t < 3; t++) begin
      in_data = toks[t];
      #1; eval();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready tok%0d got %b exp 1", t, in_ready); end
      checks++; if (out_valid !== 3'b111) begin errors++; $display("FAIL b2b out_valid tok%0d got %b exp 111", t, out_valid); end
      checks++; if (out_data !== toks[t]) begin errors++; $display("FAIL b2b out_data got %h exp %h", out_data, toks[t]); end
      for (int i = 0; i < N; i++) dfire[i] += int'(out_valid[i] & out_ready[i]);
      tick();
    end
    in_valid = 0;
    #1;
    checks++; if (tok_cnt !== 4'd3) begin errors++; $display("FAIL b2b tok_cnt got %0d exp 3", tok_cnt); end
    for (int i = 0; i < N; i++) begin
      checks++; if (dfire[i] != 3) begin errors++; $display("FAIL b2b fires branch%0d got %0d exp 3", i, dfire[i]); end
    end
  endtask

  task automatic test_partial();
    en = 3'b011; sel = 3'b011; in_valid = 1; in_data = DW'($urandom); out_ready = 3'b001;
    #1; eval();
    checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL partial c0 out_valid got %b exp %b", out_valid, e_ov); end
    checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL partial c0 in_ready got %b exp %b", in_ready, e_ready); end
    tick();
    out_ready = 3'b010;
    #1; eval();
    checks++; if (pending !== e_pend) begin errors++; $display("FAIL partial c1 pending got %b exp %b", pending, e_pend); end
    checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL partial c1 in_ready got %b exp %b", in_ready, e_ready); end
    checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL partial c1 out_valid got %b exp %b", out_valid, e_ov); end
    tick();
    out_ready = '1;
    tick();
    in_valid = 0;
  endtask

  task automatic test_sink();
    in_valid = 1; out_ready = '0;
    for (int c = 0; c < 4; c++) begin
      en  = (c < 2) ? '0 : N'($urandom);
      sel = (c < 2) ? N'($urandom) : '0;
      in_data = DW'($urandom);
      #1; eval();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sink in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== '0) begin errors++; $display("FAIL sink out_valid got %b exp 000", out_valid); end
      tick();
    end
    in_valid = 0;
    #1;
    checks++; if (tok_cnt !== CW'(mcnt)) begin errors++; $display("FAIL sink tok_cnt got %0d exp %0d", tok_cnt, mcnt); end
  endtask

  task automatic test_deselect();
    en = 3'b011; sel = 3'b011; in_valid = 1; out_ready = 3'b001; in_data = DW'($urandom);
    tick();
    sel = 3'b001; out_ready = '0;
    #1; eval();
    checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL desel in_ready got %b exp %b", in_ready, e_ready); end
    checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL desel out_valid got %b exp %b", out_valid, e_ov); end
    tick();
    #1; eval();
    checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL desel next out_valid got %b exp %b", out_valid, e_ov); end
    checks++; if (pending !== e_pend) begin errors++; $display("FAIL desel next pending got %b exp %b", pending, e_pend); end
    out_ready = '1;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset_mid();
    en = 3'b011; sel = 3'b011; in_valid = 1; out_ready = 3'b001; in_data = DW'($urandom);
    tick();
    reset = 1; out_ready = '0;
    tick();
    reset = 0;
    #1; eval();
    checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL rstmid out_valid got %b exp %b", out_valid, e_ov); end
    checks++; if (pending !== e_pend) begin errors++; $display("FAIL rstmid pending got %b exp %b", pending, e_pend); end
    checks++; if (tok_cnt !== '0) begin errors++; $display("FAIL rstmid tok_cnt got %0d exp 0", tok_cnt); end
    out_ready = '1;
    tick();
    in_valid = 0;
  endtask

  task automatic test_saturate();
    en = '1; sel = '1; out_ready = '1; in_valid = 1; cnt_clr = 1;
    tick();
    cnt_clr = 0;
    for (int k = 0; k < 17; k++) begin
      in_data = DW'($urandom);
      tick();
    end
    in_valid = 0;
    #1;
    checks++; if (tok_cnt !== 4'hF) begin errors++; $display("FAIL sat tok_cnt got %0d exp 15", tok_cnt); end
    in_valid = 1; cnt_clr = 1;
    tick();
    in_valid = 0; cnt_clr = 0;
    #1;
    checks++; if (tok_cnt !== '0) begin errors++; $display("FAIL clr_acc tok_cnt got %0d exp 0", tok_cnt); end
    in_valid = 1;
    tick();
    in_valid = 0;
    #1;
    checks++; if (tok_cnt !== 4'd1) begin errors++; $display("FAIL post_clr tok_cnt got %0d exp 1", tok_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en = N'($urandom); sel = N'($urandom); out_ready = N'($urandom);
      in_data = DW'($urandom);
      in_valid = any_got() ? 1'b1 : ($urandom_range(3) != 0);
      cnt_clr = ($urandom_range(31) == 0);
      reset = ($urandom_range(63) == 0);
      #1; eval();
      checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rnd%0d in_ready got %b exp %b", c, in_ready, e_ready); end
      checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL rnd%0d out_valid got %b exp %b", c, out_valid, e_ov); end
      checks++; if (pending !== e_pend) begin errors++; $display("FAIL rnd%0d pending got %b exp %b", c, pending, e_pend); end
      checks++; if (out_data !== in_data) begin errors++; $display("FAIL rnd%0d out_data got %h exp %h", c, out_data, in_data); end
      checks++; if (tok_cnt !== CW'(mcnt)) begin errors++; $display("FAIL rnd%0d tok_cnt got %0d exp %0d", c, tok_cnt, mcnt); end
      tick();
    end
    reset = 0; cnt_clr = 0; in_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) got[i] = 1'b0;
    mcnt = 0;
    test_reset();
    test_back_to_back();
    test_partial();
    test_sink();
    test_deselect();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fanout_fork_eager.md
# fanout_fork_eager

Parametrised eager-fork handshake unit for the Onyx streaming fabric. One upstream valid/ready stream is broadcast to `NUM_OUT` consumers. Each consumer is gated by a tile enable and a route-select configuration bit, and is served independently. A per-branch delivered-flag register lets fast consumers take the token before slow ones without seeing it twice. It is the sequential successor to the combinational ready-AND fanout: generalised in channel count and data width, with partial-delivery tracking and a token counter added.

## Interface
Parameters:
- `NUM_OUT`, 9, number of consumer branches (≥1)
- `DATA_W`, 32, payload width
- `CNT_W`, 16, width of the accepted-token counter

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream token valid
- `in_data`  in  DATA_W  upstream payload
- `in_ready`  out  1  upstream token consumed this cycle (when `in_valid`)
- `en`  in  NUM_OUT  per-branch tile enable
- `sel`  in  NUM_OUT  per-branch route select (config)
- `out_valid`  out  NUM_OUT  per-branch valid
- `out_data`  out  DATA_W  shared payload, equal to `in_data`
- `out_ready`  in  NUM_OUT  per-branch ready
- `pending`  out  NUM_OUT  branches still owed the current token
- `cnt_clr`  in  1  synchronous clear of `tok_cnt`
- `tok_cnt`  out  CNT_W  saturating count of accepted input tokens

## Operation
- `active[i] = en[i] & sel[i]`. This is evaluated every cycle and is not latched.
- `done[i]` is a register: branch i has already taken the current token.
- `out_valid[i] = in_valid & active[i] & ~done[i]`.
- `fire[i] = out_valid[i] & out_ready[i]`.
- `in_ready = AND_i (~active[i] | done[i] | out_ready[i])`.
  - `in_ready` does not depend on `in_valid`.
  - All-inactive mask gives `in_ready = 1`: the token is sunk.
- Accept (`in_valid & in_ready`):
  - `done <= 0`.
  - `tok_cnt` increments, saturating at all-ones.
- Otherwise `done[i] <= done[i] | fire[i]`.
- `pending = in_valid ? (active & ~done) : 0`.
- A branch deasserting `active` mid-token is treated as delivered. Its stale `done` bit is ignored and cleared on the next accept.
- `cnt_clr` takes priority over increment.
- `in_valid` dropping while `done` is nonzero is an upstream protocol violation. `done` holds its value. The bench flags this with an assertion.

## Timing
- Zero-cycle forward latency: `out_data`/`out_valid` are combinational from the inputs.
- The single-cycle all-ready case accepts one token per cycle.
- Reset values:
  - `done = 0`, `tok_cnt = 0`.
  - `in_ready = 1` if no branch active, else per the ready equation.
  - `out_valid = 0` when `in_valid = 0`.
  - `pending = 0`.
- Reset mid-token discards delivery progress. The token is re-offered to all active branches, so upstream must reset in the same cycle.
- Simultaneous final `fire` and accept in one cycle: accept wins and `done` clears.

## Configuration
- `FANOUT_EAGER_EN` defined: eager fork exactly as above.
- Undefined: lazy fork.
  - The `done` register is not built; `pending` is tied to `in_valid ? active : 0`.
  - `out_valid[i] = in_valid & active[i] & in_ready`, so all branches fire in the same cycle.
  - `in_ready` and `tok_cnt` behave identically.

## Structure
- Package `fanout_pkg` holds:
  - default constants `FANOUT_NUM_OUT_DEF`, `FANOUT_DATA_W_DEF`, `FANOUT_CNT_W_DEF`;
  - the `fanout_mask_t` typedef, which is `NUM_OUT` bits at the default.
- One sub-module: `fanout_tok_counter`, a CNT_W saturating counter with clear and increment inputs.

## Test plan
- NUM_OUT=3, all active, `out_ready=111`, tokens 0xA,0xB,0xC back-to-back → each accepted in one cycle; every `out_valid` high once per token; `tok_cnt=3`.
- Two active branches, `out_ready=01` in cycle 0 then `10` in cycle 1 → branch0 fires in cycle 0 only; `pending=10` in cycle 1; `in_ready=1` in cycle 1; no duplicate on branch0.
- `en=0` or `sel=0` on all branches, `in_valid=1` for 4 cycles → `in_ready=1`, `out_valid=0`, `tok_cnt=4`.
- Branch1 deselected while owed a token (`sel` 11→01 after branch0 fired) → accept in that cycle; `done` cleared.
- `reset` asserted with `done=01` → next cycle `done=0`, `tok_cnt=0`; token re-offered to both branches.
- CNT_W=4: 17 accepts → `tok_cnt=15`; `cnt_clr` together with an accept → `tok_cnt=0`. Repeat both runs with `FANOUT_EAGER_EN` undefined → fires are simultaneous only.
